// File: rtl/bus_transfer_sequencer_if.sv
// Command handshake and bus-enable bundle between the microcode controller
// (master) and the bus transfer sequencer (slave).
interface bus_transfer_sequencer_if #(
  parameter int NUM_SRC = 9,
  parameter int SRC_W   = 4,
  parameter int NUM_DST = 12
);
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic [SRC_W-1:0]   i_cmd_src;
  logic [NUM_DST-1:0] i_cmd_dst;
  logic               i_abort;
  logic [NUM_SRC-1:0] o_src_out;
  logic [NUM_DST-1:0] o_dst_load;
  logic               o_busy;
  logic               o_done;
  logic               o_err;

  modport master (
    output i_cmd_valid, i_cmd_src, i_cmd_dst, i_abort,
    input  o_cmd_ready, o_src_out, o_dst_load, o_busy, o_done, o_err
  );

  modport slave (
    input  i_cmd_valid, i_cmd_src, i_cmd_dst, i_abort,
    output o_cmd_ready, o_src_out, o_dst_load, o_busy, o_done, o_err
  );
endinterface

// File: rtl/bus_transfer_sequencer.sv
// Runs one register transfer per command on the OR-reduced bus: a single source
// drives for SETTLE_CYCLES, then the destination load strobes pulse once.
//
// state  | meaning
// IDLE   | waiting for a command; no bus driver enabled
// SETTLE | latched source drives the bus while the settle counter runs down
// LOAD   | source still driving; destination strobes and done pulse this cycle
module bus_transfer_sequencer #(
  parameter int NUM_SRC       = 9,
  parameter int SRC_W         = 4,
  parameter int NUM_DST       = 12,
  parameter int SETTLE_CYCLES = 1
) (
  input logic                     i_clk,
  input logic                     i_reset,
  bus_transfer_sequencer_if.slave bus
);

  if (SETTLE_CYCLES < 0 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 0..15");
  end
  if ((2 ** SRC_W) < NUM_SRC) begin : g_bad_src_w
    $error("SRC_W too narrow for NUM_SRC");
  end

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_LOAD   = 2'd2;

  localparam logic [3:0]   CNT_INIT  = (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);
  localparam logic [SRC_W:0] SRC_LIMIT = (SRC_W + 1)'(NUM_SRC);

  logic [1:0]         state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  logic [SRC_W-1:0]   src_q;
  logic [NUM_DST-1:0] dst_q;
  logic               ready, accept, legal;
  logic [SRC_W-1:0]   sel_src;
  logic [NUM_DST-1:0] sel_dst;
  logic [NUM_SRC-1:0] src_hot;

  logic [NUM_SRC-1:0] src_out_q;
  logic [NUM_DST-1:0] dst_load_q;
  logic               busy_q, done_q, err_q;

  assign ready  = (state == ST_IDLE) & ~bus.i_abort & ~i_reset;
  assign accept = bus.i_cmd_valid & ready;
  assign legal  = ({1'b0, bus.i_cmd_src} < SRC_LIMIT) & (|bus.i_cmd_dst);

  // Outputs are registered from the next state, so the fields being latched
  // this edge must feed the decode directly.
  assign sel_src = accept ? bus.i_cmd_src : src_q;
  assign sel_dst = accept ? bus.i_cmd_dst : dst_q;

  always_comb begin
    src_hot = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      src_hot[i] = (sel_src == i[SRC_W-1:0]);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (accept && legal) begin
          state_nxt = (SETTLE_CYCLES == 0) ? ST_LOAD : ST_SETTLE;
          cnt_nxt   = CNT_INIT;
        end
      end
      ST_SETTLE: begin
        if (bus.i_abort) begin
          state_nxt = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nxt = ST_LOAD;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      ST_LOAD:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= ST_IDLE;
      cnt        <= 4'd0;
      src_q      <= '0;
      dst_q      <= '0;
      src_out_q  <= '0;
      dst_load_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept && legal) begin
        src_q <= bus.i_cmd_src;
        dst_q <= bus.i_cmd_dst;
      end
      src_out_q  <= (state_nxt != ST_IDLE) ? src_hot : '0;
      dst_load_q <= (state_nxt == ST_LOAD) ? sel_dst : '0;
      busy_q     <= (state_nxt != ST_IDLE);
      done_q     <= (state_nxt == ST_LOAD);
      err_q      <= accept & ~legal;
    end
  end

  assign bus.o_cmd_ready = ready;
  assign bus.o_src_out   = src_out_q;
  assign bus.o_dst_load  = dst_load_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Scoreboard bench for bus_transfer_sequencer: three instances with settle
// windows of 1, 3 and 0 cycles; the instance selector equals its settle count.
module tb_bus_transfer_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int unsigned cyc = 0;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bus_transfer_sequencer_if if_n1 ();
  bus_transfer_sequencer_if if_n3 ();
  bus_transfer_sequencer_if if_n0 ();

  bus_transfer_sequencer #(.SETTLE_CYCLES(1)) u_n1 (.i_clk(clk), .i_reset(reset), .bus(if_n1.slave));
  bus_transfer_sequencer #(.SETTLE_CYCLES(3)) u_n3 (.i_clk(clk), .i_reset(reset), .bus(if_n3.slave));
  bus_transfer_sequencer #(.SETTLE_CYCLES(0)) u_n0 (.i_clk(clk), .i_reset(reset), .bus(if_n0.slave));

  typedef struct {
    int unsigned cyc;
    logic [8:0]  src;
    logic [11:0] dst;
    logic        err;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  exp_t q0[$];
  logic [8:0] prev1 = '0, prev3 = '0, prev0 = '0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int d, logic v, logic [3:0] s, logic [11:0] m, logic a);
    case (d)
      1: begin if_n1.i_cmd_valid = v; if_n1.i_cmd_src = s; if_n1.i_cmd_dst = m; if_n1.i_abort = a; end
      3: begin if_n3.i_cmd_valid = v; if_n3.i_cmd_src = s; if_n3.i_cmd_dst = m; if_n3.i_abort = a; end
      default: begin if_n0.i_cmd_valid = v; if_n0.i_cmd_src = s; if_n0.i_cmd_dst = m; if_n0.i_abort = a; end
    endcase
  endtask

  task automatic push(int d, int unsigned c, logic [8:0] s, logic [11:0] m, logic e);
    exp_t x;
    x.cyc = c; x.src = s; x.dst = m; x.err = e;
    case (d)
      1: q1.push_back(x);
      3: q3.push_back(x);
      default: q0.push_back(x);
    endcase
  endtask

  // Accept lands on the edge just stepped over (E); done follows E + settle.
  task automatic send(int d, logic [3:0] s, logic [11:0] m, logic e, logic [8:0] xs);
    drv(d, 1'b1, s, m, 1'b0);
    step();
    drv(d, 1'b0, s, m, 1'b0);
    push(d, e ? cyc : cyc + d, e ? 9'h000 : xs, e ? 12'h000 : m, e);
  endtask

  task automatic score(string nm, exp_t e, logic [8:0] so, logic [11:0] dl, logic dn, logic er);
    chk({nm, "_cycle"}, cyc, e.cyc);
    chk({nm, "_src_out"}, so, e.src);
    chk({nm, "_dst_load"}, dl, e.dst);
    chk({nm, "_err"}, er, e.err);
    chk({nm, "_done"}, dn, !e.err);
  endtask

  task automatic inv(string nm, logic [8:0] so, logic [8:0] pv, logic busy);
    chk({nm, "_onehot"}, $onehot0(so), 1);
    if (pv != 0 && so != 0) chk({nm, "_src_stable"}, so, pv);
    if (!busy) chk({nm, "_idle_src"}, so, 0);
  endtask

  task automatic unexpected(string nm, logic [8:0] so, logic [11:0] dl);
    total++;
    bad++;
    $display("FAIL %s_event: unexpected done/err at cycle %0d src_out=%0h dst_load=%0h, required none", nm, cyc, so, dl);
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      inv("n1", if_n1.o_src_out, prev1, if_n1.o_busy);
      prev1 <= if_n1.o_src_out;
      if (if_n1.o_done || if_n1.o_err) begin
        if (q1.size() == 0) unexpected("n1", if_n1.o_src_out, if_n1.o_dst_load);
        else score("n1", q1.pop_front(), if_n1.o_src_out, if_n1.o_dst_load, if_n1.o_done, if_n1.o_err);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      inv("n3", if_n3.o_src_out, prev3, if_n3.o_busy);
      prev3 <= if_n3.o_src_out;
      if (if_n3.o_done || if_n3.o_err) begin
        if (q3.size() == 0) unexpected("n3", if_n3.o_src_out, if_n3.o_dst_load);
        else score("n3", q3.pop_front(), if_n3.o_src_out, if_n3.o_dst_load, if_n3.o_done, if_n3.o_err);
      end
    end
  end

  always @(negedge clk) begin
    if (cyc >= 1) begin
      inv("n0", if_n0.o_src_out, prev0, if_n0.o_busy);
      prev0 <= if_n0.o_src_out;
      if (if_n0.o_done || if_n0.o_err) begin
        if (q0.size() == 0) unexpected("n0", if_n0.o_src_out, if_n0.o_dst_load);
        else score("n0", q0.pop_front(), if_n0.o_src_out, if_n0.o_dst_load, if_n0.o_done, if_n0.o_err);
      end
    end
  end

  initial begin
    int unsigned e;
    drv(3, 1'b0, 4'd0, 12'h000, 1'b0);
    drv(0, 1'b0, 4'd0, 12'h000, 1'b0);
    drv(1, 1'b1, 4'd7, 12'h001, 1'b0);

    // Reset held two cycles with a legal command pending.
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_src_out", if_n1.o_src_out, 0);
      chk("rst_dst_load", if_n1.o_dst_load, 0);
      chk("rst_busy", if_n1.o_busy, 0);
      chk("rst_done", if_n1.o_done, 0);
      chk("rst_err", if_n1.o_err, 0);
      chk("rst_ready", if_n1.o_cmd_ready, 0);
    end
    reset = 1'b0;
    drv(1, 1'b0, 4'd7, 12'h001, 1'b0);
    #1;
    chk("rst_release_ready", if_n1.o_cmd_ready, 1);

    // Basic transfer: ALU onto the bus, one loader.
    send(1, 4'd7, 12'h001, 1'b0, 9'h080);
    chk("basic_c1_src", if_n1.o_src_out, 9'h080);
    chk("basic_c1_done", if_n1.o_done, 0);
    chk("basic_c1_busy", if_n1.o_busy, 1);
    step();
    step();
    chk("basic_c3_ready", if_n1.o_cmd_ready, 1);
    chk("basic_c3_src", if_n1.o_src_out, 0);

    // Several loaders at once.
    send(1, 4'd4, 12'hA51, 1'b0, 9'h010);
    step();
    step();

    // Back-to-back with valid held; fields changed mid-transfer are ignored.
    drv(1, 1'b1, 4'd0, 12'h003, 1'b0);
    step();
    e = cyc;
    push(1, e + 1, 9'h001, 12'h003, 1'b0);
    drv(1, 1'b1, 4'd8, 12'h003, 1'b0);
    step();
    chk("b2b_ready_load", if_n1.o_cmd_ready, 0);
    step();
    chk("b2b_ready_idle", if_n1.o_cmd_ready, 1);
    step();
    push(1, e + 4, 9'h100, 12'h003, 1'b0);
    drv(1, 1'b0, 4'd8, 12'h003, 1'b0);
    step();
    step();
    chk("b2b_ready_after", if_n1.o_cmd_ready, 1);

    // Illegal commands: out-of-range source, empty mask, max index.
    send(1, 4'd9, 12'h001, 1'b1, 9'h000);
    chk("ill_src9_src_out", if_n1.o_src_out, 0);
    chk("ill_src9_busy", if_n1.o_busy, 0);
    chk("ill_src9_ready", if_n1.o_cmd_ready, 1);
    step();
    send(1, 4'd2, 12'h000, 1'b1, 9'h000);
    chk("ill_dst0_load", if_n1.o_dst_load, 0);
    step();
    send(1, 4'd15, 12'hFFF, 1'b1, 9'h000);
    step();

    // Abort while idle blocks the handshake and has no other effect.
    drv(1, 1'b1, 4'd7, 12'h001, 1'b1);
    #1;
    chk("abort_idle_ready", if_n1.o_cmd_ready, 0);
    step();
    drv(1, 1'b0, 4'd7, 12'h001, 1'b0);
    #1;
    chk("abort_idle_busy", if_n1.o_busy, 0);
    chk("abort_idle_src", if_n1.o_src_out, 0);

    // Abort in the load cycle keeps the already-registered strobe.
    send(1, 4'd5, 12'h800, 1'b0, 9'h020);
    step();
    drv(1, 1'b0, 4'd5, 12'h800, 1'b1);
    #1;
    chk("abort_load_ready", if_n1.o_cmd_ready, 0);
    step();
    drv(1, 1'b0, 4'd5, 12'h800, 1'b0);
    #1;
    chk("abort_load_after_src", if_n1.o_src_out, 0);
    chk("abort_load_after_dst", if_n1.o_dst_load, 0);
    chk("abort_load_after_busy", if_n1.o_busy, 0);

    // Abort in the second settle cycle of a 3-cycle window.
    drv(3, 1'b1, 4'd6, 12'h0F0, 1'b0);
    step();
    drv(3, 1'b0, 4'd6, 12'h0F0, 1'b0);
    #1;
    chk("abort_settle_c1_src", if_n3.o_src_out, 9'h040);
    step();
    drv(3, 1'b0, 4'd6, 12'h0F0, 1'b1);
    #1;
    chk("abort_settle_c2_src", if_n3.o_src_out, 9'h040);
    chk("abort_settle_c2_ready", if_n3.o_cmd_ready, 0);
    step();
    drv(3, 1'b0, 4'd6, 12'h0F0, 1'b0);
    #1;
    chk("abort_settle_src", if_n3.o_src_out, 0);
    chk("abort_settle_dst", if_n3.o_dst_load, 0);
    chk("abort_settle_done", if_n3.o_done, 0);
    chk("abort_settle_busy", if_n3.o_busy, 0);
    chk("abort_settle_ready", if_n3.o_cmd_ready, 1);
    for (int i = 0; i < 4; i++) step();

    // Full 3-cycle settle window.
    send(3, 4'd1, 12'h002, 1'b0, 9'h002);
    for (int i = 0; i < 5; i++) step();

    // Zero settle: load in the first cycle after accept.
    send(0, 4'd8, 12'h00C, 1'b0, 9'h100);
    chk("n0_c1_src", if_n0.o_src_out, 9'h100);
    chk("n0_c1_dst", if_n0.o_dst_load, 12'h00C);
    step();
    chk("n0_c2_ready", if_n0.o_cmd_ready, 1);
    chk("n0_c2_src", if_n0.o_src_out, 0);

    for (int i = 0; i < 3; i++) step();
    chk("n1_pending", q1.size(), 0);
    chk("n3_pending", q3.size(), 0);
    chk("n0_pending", q0.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
